stack_calc: RTL and testbench
=============================

STACK_CALC -- requirements
Module: stack_calc

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 3, the address width of the attached stack; stack capacity NUM_WORDS = 2**ADDR_BITS.
REQ-002 SHALL have parameter WORD_BITS, default 8, the width of operand, result and stack word.
REQ-003 SHALL use one clock and an asynchronous, active-low reset:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have the following token ports:
- in_valid  input  1  token present.
- in_is_op  input  1  1 = operator token, 0 = operand token.
- in_data  input  WORD_BITS  operand value, or opcode in bits [2:0].
- out_ready  output  1  token accepted when in_valid && out_ready.
REQ-005 SHALL have the following stack-side ports:
- out_stack_cmd  output  2  00 nop, 01 push, 10 pop.
- out_stack_data  output  WORD_BITS  data to push.
- in_stack_top  input  WORD_BITS  current top of stack.
- in_stack_ready  input  1  stack idle and ready for a command.
REQ-006 SHALL have the following status ports:
- out_result  output  WORD_BITS  last value pushed.
- out_depth  output  ADDR_BITS+1  number of stack entries, 0..NUM_WORDS.
- out_error  output  1  sticky error flag.

Function
REQ-007 SHALL implement the states Idle, IssuePop1, WaitPop1, IssuePop2, WaitPop2, IssuePush and WaitPush.
REQ-008 SHALL assert out_ready only in Idle while in_stack_ready=1.
REQ-009 SHALL drive out_stack_cmd non-nop for exactly one cycle, and only in the Issue* states; in all other states it is 00.
REQ-010 SHALL leave each Wait* state on the first cycle with in_stack_ready=1 while out_stack_cmd=00.
REQ-011 SHALL, on an accepted operand token with out_depth<NUM_WORDS, register in_data into out_stack_data and go Idle->IssuePush->WaitPush->Idle.
REQ-012 SHALL, on an accepted operator token with out_depth>=2, run the sequence below:
- In IssuePop1, capture B = in_stack_top.
- On exit from WaitPop1, capture A = in_stack_top.
- In IssuePop2, issue the second pop.
- On exit from WaitPop2, load out_stack_data = A op B.
- Go IssuePush->WaitPush->Idle.
REQ-013 SHALL decode these opcodes: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B; 101 is multiply, per the Configuration section; 11x is illegal.
REQ-014 SHALL compute all arithmetic modulo 2**WORD_BITS, truncating to WORD_BITS with no carry or overflow flag.
REQ-015 SHALL hold out_stack_data stable from the IssuePush cycle until WaitPush exits.
REQ-016 SHALL increment out_depth in IssuePush, decrement it in IssuePop1 and in IssuePop2, and never wrap it.
REQ-017 SHALL update out_result in IssuePush.
REQ-018 SHALL, on each of these error conditions, set out_error, issue no stack command, leave out_depth unchanged and remain in Idle:
- Operand token with out_depth=NUM_WORDS (overflow).
- Operator token with out_depth<2 (underflow).
- Illegal opcode.
REQ-019 SHALL keep out_error at 1 until reset; tokens accepted while out_error=1 are processed normally.
REQ-020 SHALL ignore in_valid outside Idle; the token source holds a token until out_ready.
REQ-021 SHALL keep operand-token latency from acceptance to in_stack_ready at 3 cycles with the 2-cycle push stack.

Reset
REQ-022 SHALL, while in_rst=0, force asynchronously: state=Idle, out_stack_cmd=00, out_stack_data=0, out_result=0, out_depth=0, out_error=0, A=B=0.
REQ-023 SHALL abort any sequence in progress when reset is asserted mid-operation; the attached stack is reset by the same reset.
REQ-024 SHALL make out_ready combinational, equal to (state==Idle && in_stack_ready), and therefore low during reset.

Configuration
REQ-025 SHALL make opcode 101 compute the WORD_BITS-truncated product A*B when STACK_CALC_MUL_EN is defined.
REQ-026 SHALL treat opcode 101 as illegal when STACK_CALC_MUL_EN is undefined, per REQ-018, and synthesise no multiplier.

Verification (ADDR_BITS=3, WORD_BITS=8)
REQ-027 SHALL cover: push 5, push 3, op 001 -> out_result=2, out_depth=1, in_stack_top=2, out_error=0.
REQ-028 SHALL cover: push 200, push 100, op 000 -> out_result=44 (wrap); exactly 2 pops then 1 push observed on out_stack_cmd.
REQ-029 SHALL cover: push 7, op 000 -> out_error=1, out_depth=1, out_stack_cmd stays 00.
REQ-030 SHALL cover: 9 operand pushes -> the 9th sets out_error=1, out_depth=8, and only 8 push commands are issued.
REQ-031 SHALL cover: push 12, push 13, op 101 -> out_result=156 with STACK_CALC_MUL_EN; without it, out_error=1 and out_depth=2.
REQ-032 SHALL cover: in_rst=0 during WaitPop2 -> out_depth=0, out_error=0, out_stack_cmd=00 immediately; after release, push 1 -> out_result=1.

Source files
------------

// File: rtl/stack_calc.sv
// stack_calc: RPN calculator sequencing an external push/pop stack.
// Define STACK_CALC_MUL_EN to enable opcode 101 (multiply); otherwise 101 is illegal.
module stack_calc #(
    parameter int ADDR_BITS = 3,
    parameter int WORD_BITS = 8
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_valid,
    input  logic                 in_is_op,
    input  logic [WORD_BITS-1:0] in_data,
    output logic                 out_ready,
    output logic [1:0]           out_stack_cmd,
    output logic [WORD_BITS-1:0] out_stack_data,
    input  logic [WORD_BITS-1:0] in_stack_top,
    input  logic                 in_stack_ready,
    output logic [WORD_BITS-1:0] out_result,
    output logic [ADDR_BITS:0]   out_depth,
    output logic                 out_error
);

    localparam int NUM_WORDS = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_FULL = (ADDR_BITS + 1)'(NUM_WORDS);
    localparam logic [ADDR_BITS:0] DEPTH_TWO  = (ADDR_BITS + 1)'(2);
    localparam logic [ADDR_BITS:0] DEPTH_ONE  = (ADDR_BITS + 1)'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IPOP1  = 3'd1;
    localparam logic [2:0] S_WPOP1  = 3'd2;
    localparam logic [2:0] S_IPOP2  = 3'd3;
    localparam logic [2:0] S_WPOP2  = 3'd4;
    localparam logic [2:0] S_IPUSH  = 3'd5;
    localparam logic [2:0] S_WPUSH  = 3'd6;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;

    logic [2:0]           state;
    logic [2:0]           op_q;
    logic [WORD_BITS-1:0] a_q;
    logic [WORD_BITS-1:0] b_q;
    logic [WORD_BITS-1:0] alu;
    logic                 op_legal;
    logic                 accept;

    // Tokens are only taken when idle and the stack can take a command
    assign out_ready = (state == S_IDLE) && in_stack_ready;
    assign accept    = in_valid && out_ready;

    // Stack command is a pure function of state: one cycle per Issue state
    always_comb begin
        out_stack_cmd = CMD_NOP;
        case (state)
            S_IPOP1, S_IPOP2: out_stack_cmd = CMD_POP;
            S_IPUSH:          out_stack_cmd = CMD_PUSH;
            default:          out_stack_cmd = CMD_NOP;
        endcase
    end

    // Opcode legality for the incoming operator token
    always_comb begin
`ifdef STACK_CALC_MUL_EN
        op_legal = (in_data[2:0] <= 3'd5);
`else
        op_legal = (in_data[2:0] <= 3'd4);
`endif
    end

    // Result of A op B, truncated to the word width
    always_comb begin
        alu = '0;
        case (op_q)
            3'b000:  alu = a_q + b_q;
            3'b001:  alu = a_q - b_q;
            3'b010:  alu = a_q & b_q;
            3'b011:  alu = a_q | b_q;
            3'b100:  alu = a_q ^ b_q;
`ifdef STACK_CALC_MUL_EN
            3'b101:  alu = a_q * b_q;
`endif
            default: alu = '0;
        endcase
    end

    // Sequencer: token decode, pop/pop/push sequence, depth and error tracking
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state          <= S_IDLE;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            out_stack_data <= '0;
            out_result     <= '0;
            out_depth      <= '0;
            out_error      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!in_is_op) begin
                            if (out_depth == DEPTH_FULL) begin
                                out_error <= 1'b1;
                            end else begin
                                out_stack_data <= in_data;
                                state          <= S_IPUSH;
                            end
                        end else if (!op_legal || out_depth < DEPTH_TWO) begin
                            out_error <= 1'b1;
                        end else begin
                            op_q  <= in_data[2:0];
                            state <= S_IPOP1;
                        end
                    end
                end
                S_IPOP1: begin
                    b_q       <= in_stack_top;
                    out_depth <= out_depth - DEPTH_ONE;
                    state     <= S_WPOP1;
                end
                S_WPOP1: begin
                    if (in_stack_ready) begin
                        a_q   <= in_stack_top;
                        state <= S_IPOP2;
                    end
                end
                S_IPOP2: begin
                    out_depth <= out_depth - DEPTH_ONE;
                    state     <= S_WPOP2;
                end
                S_WPOP2: begin
                    if (in_stack_ready) begin
                        out_stack_data <= alu;
                        state          <= S_IPUSH;
                    end
                end
                S_IPUSH: begin
                    out_depth  <= out_depth + DEPTH_ONE;
                    out_result <= out_stack_data;
                    state      <= S_WPUSH;
                end
                S_WPUSH: begin
                    if (in_stack_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_calc.sv
// tb_stack_calc: directed vectors for stack_calc with a push-data scoreboard.
// Includes a behavioural 8-deep stack that is busy for one cycle after each command.
module tb_stack_calc;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_is_op;
    logic [7:0] in_data;
    logic       out_ready;
    logic [1:0] cmd;
    logic [7:0] sdata;
    logic [7:0] top;
    logic       sready;
    logic [7:0] result;
    logic [3:0] depth;
    logic       err;

    int n_chk;
    int n_fail;
    int push_cnt;
    int pop_cnt;
    logic [7:0] exp_q[$];

    logic [7:0] mem [8];
    logic [3:0] sp;
    logic       busy;
    logic [2:0] top_idx;

    stack_calc #(.ADDR_BITS(3), .WORD_BITS(8)) dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_valid       (in_valid),
        .in_is_op       (in_is_op),
        .in_data        (in_data),
        .out_ready      (out_ready),
        .out_stack_cmd  (cmd),
        .out_stack_data (sdata),
        .in_stack_top   (top),
        .in_stack_ready (sready),
        .out_result     (result),
        .out_depth      (depth),
        .out_error      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp   <= '0;
            busy <= 1'b0;
        end else begin
            busy <= 1'b0;
            if (cmd == 2'b01 && sp < 4'd8) begin
                mem[sp[2:0]] <= sdata;
                sp           <= sp + 4'd1;
                busy         <= 1'b1;
            end else if (cmd == 2'b10 && sp > 4'd0) begin
                sp   <= sp - 4'd1;
                busy <= 1'b1;
            end
        end
    end

    assign top_idx = 3'(sp - 4'd1);
    assign top     = (sp == 4'd0) ? 8'd0 : mem[top_idx];
    assign sready  = rst && !busy;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every push command must carry the next expected value
    always @(negedge clk) begin
        if (rst) begin
            if (cmd == 2'b01) begin
                push_cnt++;
                if (exp_q.size() == 0) begin
                    chk("push_unexpected", int'(sdata), -1);
                end else begin
                    chk("push_data", int'(sdata), int'(exp_q.pop_front()));
                end
            end
            if (cmd == 2'b10) pop_cnt++;
            if (cmd == 2'b11) chk("cmd_illegal", int'(cmd), 0);
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic drive(input logic is_op, input logic [7:0] d);
        wait_ready();
        in_valid = 1'b1;
        in_is_op = is_op;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_tok(input logic [7:0] d, input logic ok);
        if (ok) exp_q.push_back(d);
        drive(1'b0, d);
        wait_ready();
    endtask

    task automatic op_tok(input logic [2:0] op, input logic ok,
                          input logic [7:0] res);
        if (ok) exp_q.push_back(res);
        drive(1'b1, {5'd0, op});
        wait_ready();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    int p0;
    int q0;
    int npop;

    initial begin
        n_chk = 0; n_fail = 0; push_cnt = 0; pop_cnt = 0;
        rst = 1'b0; in_valid = 1'b0; in_is_op = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(out_ready), 0);
        chk("rst_cmd", int'(cmd), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_depth", int'(depth), 0);
        chk("rst_error", int'(err), 0);
        chk("rst_result", int'(result), 0);
        chk("idle_ready", int'(out_ready), 1);

        // 5 - 3
        push_tok(8'd5, 1'b1);
        push_tok(8'd3, 1'b1);
        op_tok(3'b001, 1'b1, 8'd2);
        chk("sub_result", int'(result), 2);
        chk("sub_depth", int'(depth), 1);
        chk("sub_top", int'(top), 2);
        chk("sub_error", int'(err), 0);

        // 200 + 100 wraps to 44; two pops then one push
        do_reset();
        push_tok(8'd200, 1'b1);
        push_tok(8'd100, 1'b1);
        p0 = push_cnt; q0 = pop_cnt;
        op_tok(3'b000, 1'b1, 8'd44);
        chk("add_wrap", int'(result), 44);
        chk("add_pops", pop_cnt - q0, 2);
        chk("add_pushes", push_cnt - p0, 1);

        // logic ops and subtract wrap
        do_reset();
        push_tok(8'hF0, 1'b1);
        push_tok(8'h3C, 1'b1);
        op_tok(3'b010, 1'b1, 8'h30);
        chk("and_result", int'(result), 'h30);
        push_tok(8'h0F, 1'b1);
        op_tok(3'b011, 1'b1, 8'h3F);
        chk("or_result", int'(result), 'h3F);
        push_tok(8'hFF, 1'b1);
        op_tok(3'b100, 1'b1, 8'hC0);
        chk("xor_result", int'(result), 'hC0);
        push_tok(8'd3, 1'b1);
        op_tok(3'b001, 1'b1, 8'd189);
        chk("sub_wrap", int'(result), 189);
        chk("logic_depth", int'(depth), 1);

        // underflow
        do_reset();
        push_tok(8'd7, 1'b1);
        p0 = push_cnt; q0 = pop_cnt;
        op_tok(3'b000, 1'b0, 8'd0);
        chk("uflow_error", int'(err), 1);
        chk("uflow_depth", int'(depth), 1);
        chk("uflow_cmds", (push_cnt - p0) + (pop_cnt - q0), 0);

        // overflow on the 9th push, then normal processing with error sticky
        do_reset();
        p0 = push_cnt;
        for (int i = 0; i < 9; i++) begin
            push_tok(8'(10 + i), i < 8);
        end
        chk("oflow_error", int'(err), 1);
        chk("oflow_depth", int'(depth), 8);
        chk("oflow_pushes", push_cnt - p0, 8);
        op_tok(3'b000, 1'b1, 8'd33);
        chk("post_err_result", int'(result), 33);
        chk("post_err_depth", int'(depth), 7);
        chk("post_err_sticky", int'(err), 1);

        // multiply or illegal 101
        do_reset();
        push_tok(8'd12, 1'b1);
        push_tok(8'd13, 1'b1);
`ifdef STACK_CALC_MUL_EN
        op_tok(3'b101, 1'b1, 8'd156);
        chk("mul_result", int'(result), 156);
        chk("mul_error", int'(err), 0);
`else
        op_tok(3'b101, 1'b0, 8'd0);
        chk("mul_off_error", int'(err), 1);
        chk("mul_off_depth", int'(depth), 2);
`endif

        // illegal opcode 11x
        do_reset();
        push_tok(8'd1, 1'b1);
        push_tok(8'd2, 1'b1);
        op_tok(3'b110, 1'b0, 8'd0);
        chk("ill_error", int'(err), 1);
        chk("ill_depth", int'(depth), 2);

        // reset during WaitPop2 (error still set from above)
        drive(1'b1, 8'd0);
        npop = 0;
        for (int i = 0; i < 30 && npop < 2; i++) begin
            @(negedge clk);
            if (cmd == 2'b10) npop++;
        end
        chk("abort_pops_seen", npop, 2);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_depth", int'(depth), 0);
        chk("abort_error", int'(err), 0);
        chk("abort_cmd", int'(cmd), 0);
        chk("abort_ready", int'(out_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push_tok(8'd1, 1'b1);
        chk("abort_push_result", int'(result), 1);
        chk("abort_push_depth", int'(depth), 1);

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
